// File: rtl/ddr_rd_responder.sv
// On-chip stand-in for the DDR read side of the search front end: host-loaded
// line store, in-order request queue and a fixed-latency valid+done response.
module ddr_rd_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  parameter int LINES_LOG2 = 10,
  parameter int RD_LATENCY = 4,
  parameter int FIFO_LOG2  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ddr_rd,
  input  logic [ADDR_WIDTH-1:0] readAdd,
  output logic                  ddr_rd_valid,
  output logic                  ddr_rd_done,
  output logic [DATA_WIDTH-1:0] ddr_rd_data,
  input  logic                  load_wr,
  input  logic [LINES_LOG2-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  busy,
  output logic                  rd_err
);

  localparam int LINES      = 1 << LINES_LOG2;
  localparam int FIFO_DEPTH = 1 << FIFO_LOG2;
  localparam int CNT_W      = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;
  localparam int LINE_W     = ADDR_WIDTH - 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ddr_rd_q;
  logic                rd_err_q, rd_err_d;
  logic [DATA_WIDTH-1:0] ddr_rd_data_q;
  logic [DATA_WIDTH-1:0] store_rdata_q;

  logic [LINES_LOG2-1:0] fifo_mem [FIFO_DEPTH];
  logic [FIFO_LOG2-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FIFO_LOG2:0]    count_q, count_d;
  logic [DATA_WIDTH-1:0] line_mem [LINES];

  logic                  capture;
  logic [LINE_W-1:0]     line_full;
  logic [LINES_LOG2-1:0] line_idx;
  logic                  addr_err;
  logic                  fifo_empty, fifo_full;
  logic                  push, pop, overflow;
  logic                  data_en;

  // Request decode: rising edge of ddr_rd, bit address to line index.
  assign capture   = ddr_rd & ~ddr_rd_q;
  assign line_full = readAdd[ADDR_WIDTH-1:9];
  assign line_idx  = line_full[LINES_LOG2-1:0];
  assign addr_err  = capture &
                     ((readAdd[8:0] != 9'd0) || ((line_full >> LINES_LOG2) != '0));

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = count_q[FIFO_LOG2];
  // A full queue still accepts a request when the head leaves in the same cycle.
  assign push       = capture & (~fifo_full | pop);
  assign overflow   = capture & fifo_full & ~pop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign rd_err_d = rd_err_q | addr_err | overflow;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    data_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cnt_d   = CNT_W'(RD_LATENCY - 1);
          state_d = FETCH;
        end
      end
      FETCH: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          data_en = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ddr_rd_q      <= 1'b0;
      rd_err_q      <= 1'b0;
      ddr_rd_data_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ddr_rd_q <= ddr_rd;
      rd_err_q <= rd_err_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (data_en) ddr_rd_data_q <= store_rdata_q;
    end
  end

  // NOTE: storage arrays carry no reset; their contents are qualified by the
  // reset pointers/state, and the host owns line-store contents across reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= line_idx;
  end

  // Same-line write and read in one cycle returns the pre-write line.
  always_ff @(posedge clk) begin
    if (load_wr) line_mem[load_addr] <= load_data;
    if (pop)     store_rdata_q <= line_mem[fifo_mem[rd_ptr_q]];
  end

  assign ddr_rd_valid = (state_q == RESP);
  assign ddr_rd_done  = (state_q == RESP);
  assign ddr_rd_data  = ddr_rd_data_q;
  assign busy         = ~fifo_empty | (state_q != IDLE);
  assign rd_err       = rd_err_q;

endmodule

// File: tb/tb_ddr_rd_responder.sv
// Directed, table-driven bench for ddr_rd_responder: latency, hold, queueing,
// address errors, same-cycle write/read, reset mid-fetch and queue overflow.
module tb_ddr_rd_responder;

  logic         clk;
  logic         rst;
  logic         ddr_rd;
  logic [31:0]  readAdd;
  logic         ddr_rd_valid;
  logic         ddr_rd_done;
  logic [511:0] ddr_rd_data;
  logic         load_wr;
  logic [9:0]   load_addr;
  logic [511:0] load_data;
  logic         busy;
  logic         rd_err;

  int checks = 0;
  int errors = 0;

  ddr_rd_responder dut (
    .clk          (clk),
    .rst          (rst),
    .ddr_rd       (ddr_rd),
    .readAdd      (readAdd),
    .ddr_rd_valid (ddr_rd_valid),
    .ddr_rd_done  (ddr_rd_done),
    .ddr_rd_data  (ddr_rd_data),
    .load_wr      (load_wr),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .busy         (busy),
    .rd_err       (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic [511:0] exp_data;
    logic         exp_err;
  } vec_t;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load_line(input logic [9:0] idx, input logic [511:0] data);
    load_wr   = 1'b1;
    load_addr = idx;
    load_data = data;
    step();
    load_wr   = 1'b0;
  endtask

  // One-cycle request pulse; lat is the cycle offset of the response after the
  // capture edge, or -1 if none arrives within the budget.
  task automatic do_read(input logic [31:0] addr, output logic [511:0] data, output int lat);
    ddr_rd  = 1'b1;
    readAdd = addr;
    step();
    ddr_rd  = 1'b0;
    lat     = -1;
    data    = '0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (ddr_rd_valid) begin
        data = ddr_rd_data;
        lat  = k;
        break;
      end
    end
    step();
  endtask

  // Done must mirror valid on every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) check("done_eq_valid", ddr_rd_done, ddr_rd_valid);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] pat_a, pat_b, pat_c, pat_2, pat_3, pat_4, d;
    logic [511:0] d_resp [8];
    logic [511:0] exp_seq [8];
    int           c_resp [8];
    int           lat, nv, nr, first_k;
    vec_t         vecs [8];

    pat_a = {16{32'hA5A5_0000}};
    pat_b = {16{32'hB00B_1111}};
    pat_c = {16{32'hC3C3_2222}};
    pat_2 = {16{32'h2222_D00D}};
    pat_3 = {16{32'h3333_E00E}};
    pat_4 = {16{32'h4444_F00F}};

    vecs[0] = '{32'd0,              pat_a, 1'b0};
    vecs[1] = '{32'd512,            pat_b, 1'b0};
    vecs[2] = '{32'd1024,           pat_2, 1'b0};
    vecs[3] = '{32'd1536,           pat_3, 1'b0};
    vecs[4] = '{32'd520,            pat_b, 1'b1};
    vecs[5] = '{32'd524288,         pat_a, 1'b1};
    vecs[6] = '{32'd525825,         pat_3, 1'b1};
    vecs[7] = '{32'hFFFF_FE00,      pat_4, 1'b1};

    rst = 1'b1; ddr_rd = 1'b0; readAdd = '0;
    load_wr = 1'b0; load_addr = '0; load_data = '0;
    step(); step(); step();
    check("rst_valid", ddr_rd_valid, 1'b0);
    check("rst_done",  ddr_rd_done,  1'b0);
    check("rst_busy",  busy,         1'b0);
    check("rst_err",   rd_err,       1'b0);
    check("rst_data",  ddr_rd_data,  '0);
    rst = 1'b0;
    step();

    load_line(10'd0,    pat_a);
    load_line(10'd1,    pat_b);
    load_line(10'd2,    pat_2);
    load_line(10'd3,    pat_3);
    load_line(10'd1023, pat_4);
    step();

    // Single request: pulse only at T+4, busy through T+4, data held after.
    ddr_rd = 1'b1; readAdd = 32'd0;
    step();
    ddr_rd = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("t1_valid_T+%0d", k), ddr_rd_valid, (k == 4));
      if (k <= 4) check($sformatf("t1_busy_T+%0d", k), busy, 1'b1);
      if (k == 5) check("t1_busy_T+5", busy, 1'b0);
      if (k >= 4) check($sformatf("t1_data_T+%0d", k), ddr_rd_data, pat_a);
    end

    // Held request is a single request.
    nv = 0; first_k = -1; d = '0;
    ddr_rd = 1'b1; readAdd = 32'd512;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) ddr_rd = 1'b0;
      step();
      if (ddr_rd_valid) begin
        nv++;
        d = ddr_rd_data;
        if (first_k < 0) first_k = k;
      end
    end
    check("t2_pulses", nv, 1);
    check("t2_latency", first_k, 4);
    check("t2_data", d, pat_b);

    // Five edges two cycles apart: in-order responses five cycles apart.
    nr = 0;
    for (int c = 0; c < 40; c++) begin
      ddr_rd  = (c < 10) && (c % 2 == 0);
      readAdd = ((c / 2) % 2 == 1) ? 32'd512 : 32'd0;
      step();
      if (ddr_rd_valid) begin
        if (nr < 8) begin
          c_resp[nr] = c;
          d_resp[nr] = ddr_rd_data;
        end
        nr++;
      end
    end
    ddr_rd = 1'b0;
    check("t3_count", nr, 5);
    check("t3_first_at", c_resp[0], 4);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_data_%0d", i), d_resp[i], (i % 2 == 1) ? pat_b : pat_a);
      if (i > 0) check($sformatf("t3_gap_%0d", i), c_resp[i] - c_resp[i-1], 5);
    end
    check("t3_err", rd_err, 1'b0);

    // Address table: aligned reads first, then misaligned / out-of-range.
    for (int i = 0; i < 8; i++) begin
      do_read(vecs[i].addr, d, lat);
      check($sformatf("tab%0d_latency", i), lat, 4);
      check($sformatf("tab%0d_data", i), d, vecs[i].exp_data);
      check($sformatf("tab%0d_err", i), rd_err, vecs[i].exp_err);
    end

    // Same-cycle write and store read of line 0 returns the old line.
    ddr_rd = 1'b1; readAdd = 32'd0;
    step();
    ddr_rd = 1'b0;
    load_wr = 1'b1; load_addr = 10'd0; load_data = pat_c;
    step();
    load_wr = 1'b0;
    lat = -1; d = '0;
    for (int k = 2; k <= 20; k++) begin
      step();
      if (ddr_rd_valid) begin
        d = ddr_rd_data;
        lat = k;
        break;
      end
    end
    step();
    check("t5_latency", lat, 4);
    check("t5_old_data", d, pat_a);
    do_read(32'd0, d, lat);
    check("t5_new_data", d, pat_c);

    // Reset while fetching: no late pulse, outputs cleared, service resumes.
    ddr_rd = 1'b1; readAdd = 32'd512;
    step();
    ddr_rd = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    check("t6_valid", ddr_rd_valid, 1'b0);
    check("t6_busy",  busy,         1'b0);
    check("t6_err",   rd_err,       1'b0);
    check("t6_data",  ddr_rd_data,  '0);
    rst = 1'b0;
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (ddr_rd_valid) nv++;
    end
    check("t6_no_pulse", nv, 0);
    do_read(32'd512, d, lat);
    check("t6_after_latency", lat, 4);
    check("t6_after_data", d, pat_b);

    // Overflow: eighth edge hits a full queue with no pop and is dropped.
    for (int i = 0; i < 7; i++) exp_seq[i] = (i % 2 == 1) ? pat_b : pat_c;
    nr = 0;
    for (int c = 0; c < 50; c++) begin
      ddr_rd  = (c < 16) && (c % 2 == 0);
      readAdd = ((c / 2) % 2 == 1) ? 32'd512 : 32'd0;
      step();
      if (c == 13) check("ovf_err_before", rd_err, 1'b0);
      if (c == 14) check("ovf_err_after",  rd_err, 1'b1);
      if (ddr_rd_valid) begin
        if (nr < 8) d_resp[nr] = ddr_rd_data;
        nr++;
      end
    end
    ddr_rd = 1'b0;
    check("ovf_count", nr, 7);
    for (int i = 0; i < 7; i++) check($sformatf("ovf_data_%0d", i), d_resp[i], exp_seq[i]);
    check("ovf_idle_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
